// File: rtl/stream_demux_1to8_pkg.sv
// Shared constants and types for the 1-to-8 stream demultiplexer.
package stream_demux_1to8_pkg;

    localparam int unsigned NUM_OUT = 8;
    localparam int unsigned SEL_W   = 3;

    typedef logic [SEL_W-1:0] chan_idx_t;

endpackage

// File: rtl/stream_demux_1to8_slot.sv
// One-entry output register for a single demux channel; a load overrides a same-cycle drain.
module demux_slot #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [N-1:0] data,
    output logic         can_load
);

    assign can_load = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            // data keeps its last value after draining
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1to8.sv
// Routes one valid/ready input word per cycle to one of eight independently drained channels.
module stream_demux_1to8
    import stream_demux_1to8_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*N-1:0]       out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [COUNT_W-1:0]   accept_count
);

    logic [NUM_OUT-1:0] can_load;
    logic [NUM_OUT-1:0] load;
    logic               accept;
    chan_idx_t          sel;

    assign sel      = chan_idx_t'(in_sel);
    assign in_ready = !rst && can_load[sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            load[sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(
            .N (N)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*N +: N]),
            .can_load  (can_load[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accept_count <= '0;
        end else if (accept) begin
            accept_count <= accept_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_demux_1to8.sv
// Directed bench for stream_demux_1to8, built with a 4-bit counter so the wrap is reachable.
module tb_stream_demux_1to8;

    localparam int unsigned N       = 32;
    localparam int unsigned COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       in_data;
    logic [2:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [8*N-1:0]     out_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic [COUNT_W-1:0] accept_count;

    int checks = 0;
    int errors = 0;

    stream_demux_1to8 #(
        .N       (N),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] chan(input int unsigned k);
        return out_data[k*N +: N];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [COUNT_W-1:0] wrap_exp [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_data   = 32'h0000_1234;
        out_ready = 8'h00;

        // reset held two cycles with a word offered
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'h00);
            check("rst_count", 64'(accept_count), 64'd0);
            check("rst_data_zero", 64'(|out_data), 64'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'h00);
        check("post_rst_count", 64'(accept_count), 64'd0);

        // single route to channel 5
        in_data  = 32'hDEAD_BEEF;
        in_sel   = 3'd5;
        in_valid = 1'b1;
        #1;
        check("route_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("route_valid", 64'(out_valid), 64'h20);
        check("route_data5", 64'(chan(5)), 64'hDEAD_BEEF);
        check("route_count", 64'(accept_count), 64'd1);
        out_ready = 8'h20;
        tick();
        out_ready = 8'h00;
        check("drain_valid", 64'(out_valid), 64'h00);
        check("drain_data_kept", 64'(chan(5)), 64'hDEAD_BEEF);
        check("drain_count", 64'(accept_count), 64'd1);

        // backpressure on channel 2, then redirect to channel 3
        in_data  = 32'hAAAA_0002;
        in_sel   = 3'd2;
        in_valid = 1'b1;
        tick();
        check("bp_fill_valid", 64'(out_valid), 64'h04);
        in_data = 32'hBBBB_0002;
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("bp_held_valid", 64'(out_valid), 64'h04);
        check("bp_held_data2", 64'(chan(2)), 64'hAAAA_0002);
        check("bp_count", 64'(accept_count), 64'd2);
        in_sel  = 3'd3;
        in_data = 32'hCCCC_0003;
        #1;
        check("bp_alt_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_alt_valid", 64'(out_valid), 64'h0C);
        check("bp_alt_data3", 64'(chan(3)), 64'hCCCC_0003);
        check("bp_alt_data2", 64'(chan(2)), 64'hAAAA_0002);
        check("bp_alt_count", 64'(accept_count), 64'd3);
        out_ready = 8'h0C;
        tick();
        out_ready = 8'h00;
        check("bp_drain_valid", 64'(out_valid), 64'h00);

        // full-rate stream through channel 0 with simultaneous drain and load
        out_ready = 8'h01;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = N'(i);
            #1;
            check("tp_in_ready", 64'(in_ready), 64'd1);
            tick();
            check("tp_data0", 64'(chan(0)), 64'(i));
            check("tp_valid0", 64'(out_valid), 64'h01);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 8'h00;
        check("tp_end_valid", 64'(out_valid), 64'h00);
        check("tp_count", 64'(accept_count), 64'd13);

        // accepts 14..17 on channel 6: count wraps to 0 at the 16th
        out_ready = 8'h40;
        in_sel    = 3'd6;
        in_valid  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 32'h6666_0000 + N'(j);
            tick();
            check("wrap_count", 64'(accept_count), 64'(wrap_exp[j]));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 8'h00;

        // fill channels 1, 4, 7 then reset mid-operation
        in_valid = 1'b1;
        in_sel = 3'd1; in_data = 32'h1111_1111; tick();
        in_sel = 3'd4; in_data = 32'h4444_4444; tick();
        in_sel = 3'd7; in_data = 32'h7777_7777; tick();
        check("mid_fill_valid", 64'(out_valid), 64'h92);
        check("mid_fill_count", 64'(accept_count), 64'd4);
        rst    = 1'b1;
        in_sel = 3'd0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'h00);
        check("mid_rst_data_zero", 64'(|out_data), 64'd0);
        check("mid_rst_count", 64'(accept_count), 64'd0);
        in_valid = 1'b1;
        in_sel   = 3'd1;
        in_data  = 32'h0000_00A1;
        #1;
        check("resume_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("resume_valid", 64'(out_valid), 64'h02);
        check("resume_data1", 64'(chan(1)), 64'h0000_00A1);
        check("resume_count", 64'(accept_count), 64'd1);

        // idle input with a full-channel select must change nothing
        in_sel = 3'd1;
        tick();
        check("idle_valid", 64'(out_valid), 64'h02);
        check("idle_count", 64'(accept_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
